cb_config_controller: RTL and testbench

- Configuration sequencer for a bank of NUM_CB connection boxes sharing one config_addr/config_data bus, each with its own config_en strobe and read_data return.
- Accepts one host command at a time (write or read) over a valid/ready handshake and decodes the target box from the address upper byte.
- Drives the shared config bus with correct strobe timing and returns a response over a second valid/ready handshake.
- After every reset it sweeps all boxes, writing INIT_VALUE to register 0, before accepting host commands.

---
 rtl/cb_config_controller.sv | 112 +++++++++++
 tb/tb_cb_config_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cb_config_controller.sv
// cb_config_controller: sequences init sweep and host read/write commands onto a shared connection-box config bus
module cb_config_controller #(
  parameter int NUM_CB = 4,
  parameter int WRITE_HOLD = 2,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_error,
  output logic [31:0]          config_addr,
  output logic [31:0]          config_data,
  output logic [NUM_CB-1:0]    config_en,
  input  logic [NUM_CB*32-1:0] cb_read_data,
  output logic                 busy
);
  localparam int IW = NUM_CB > 1 ? $clog2(NUM_CB) : 1;
  localparam int CW = $clog2(WRITE_HOLD + 1);
  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, RESP} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] tgt, tgt_d;
  logic accept, bad, last_hold, rsp_done;
  logic ready_d, rsp_valid_d, rsp_error_d;
  logic [NUM_CB-1:0] sweep_en, write_en, en_d;
  logic [31:0] rd_sel, addr_d, data_d, rsp_data_d;
  assign accept = cmd_valid & cmd_ready;
  assign bad = cmd_addr[31:24] >= 8'(NUM_CB);
  assign last_hold = cnt == CW'(WRITE_HOLD - 1);
  assign rsp_done = rsp_valid & rsp_ready;
  always_comb begin
    sweep_en = '0;
    write_en = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_CB; i++) begin
      sweep_en[i] = idx == IW'(i);
      write_en[i] = tgt == 8'(i);
      if (tgt == 8'(i)) rd_sel = cb_read_data[32*i +: 32];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      idx <= '0;
      cnt <= '0;
      tgt <= '0;
      config_en <= '0;
      config_addr <= '0;
      config_data <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_error <= 1'b0;
      cmd_ready <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= state_d;
      idx <= idx_d;
      cnt <= cnt_d;
      tgt <= tgt_d;
      config_en <= en_d;
      config_addr <= addr_d;
      config_data <= data_d;
      rsp_valid <= rsp_valid_d;
      rsp_data <= rsp_data_d;
      rsp_error <= rsp_error_d;
      cmd_ready <= ready_d;
      busy <= ~ready_d;
    end
  end
  always_comb begin
    state_d = state;
    idx_d = idx;
    cnt_d = cnt;
    tgt_d = accept ? cmd_addr[31:24] : tgt;
    case (state)
      INIT: begin
        cnt_d = last_hold ? '0 : cnt + CW'(1);
        if (last_hold && idx == IW'(NUM_CB - 1)) state_d = IDLE;
        else if (last_hold) idx_d = idx + IW'(1);
      end
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = bad ? RESP : cmd_write ? WRITE : READ;
      end
      WRITE: begin
        cnt_d = last_hold ? '0 : cnt + CW'(1);
        if (last_hold) state_d = RESP;
      end
      READ: state_d = RESP;
      RESP: if (rsp_done) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  // outputs are registered one edge behind the state that produces them, except cmd_ready which drops on the accept edge
  always_comb begin
    en_d = state == INIT ? sweep_en : state == WRITE ? write_en : '0;
    ready_d = state == IDLE && !accept;
    rsp_valid_d = state == RESP && !rsp_done;
    addr_d = state == INIT ? '0 : accept ? {8'h0, cmd_addr[23:0]} : config_addr;
    data_d = state == INIT ? INIT_VALUE : accept ? cmd_data : config_data;
    rsp_error_d = accept ? bad : rsp_error;
    rsp_data_d = accept ? '0 : state == READ ? rd_sel : rsp_data;
  end
endmodule

// File: tb/tb_cb_config_controller.sv
// tb_cb_config_controller: directed self-checking bench for cb_config_controller
module tb_cb_config_controller;
  logic clk, reset, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0] cmd_addr, cmd_data, rsp_data, config_addr, config_data;
  logic [3:0] config_en;
  logic [127:0] cb_read_data;
  int checks = 0;
  int passes = 0;
  cb_config_controller #(.NUM_CB(4), .WRITE_HOLD(2), .INIT_VALUE(32'h0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .cb_read_data(cb_read_data), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask
  task automatic ack;
    rsp_ready = 1'b1;
    tick;
    check("ack_valid", rsp_valid, 1'b0);
    check("ack_ready", cmd_ready, 1'b0);
    rsp_ready = 1'b0;
    tick;
    check("ready_back", cmd_ready, 1'b1);
    check("busy_back", busy, 1'b0);
  endtask
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_data = d;
    tick;
    cmd_valid = 1'b0;
    check("acc_ready", cmd_ready, 1'b0);
    check("acc_busy", busy, 1'b1);
  endtask
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    cb_read_data = {32'h3333_3333, 32'h2222_2222, 32'h0007_0070, 32'h1111_1111};
    repeat (3) tick;
    check("rst_en", config_en, 4'b0);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_addr", config_addr, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      check("sweep_en", config_en, 4'b1 << (k / 2));
      check("sweep_data", config_data, 32'h0);
      check("sweep_ready", cmd_ready, 1'b0);
    end
    tick;
    check("idle_en", config_en, 4'b0);
    check("idle_ready", cmd_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    tick;
    check("idle_hold_en", config_en, 4'b0);
    issue(1'b1, 32'h0100_0006, 32'h1);
    check("wr_addr", config_addr, 32'h6);
    check("wr_data", config_data, 32'h1);
    check("wr_en0", config_en, 4'b0);
    tick;
    check("wr_en1", config_en, 4'b0010);
    tick;
    check("wr_en2", config_en, 4'b0010);
    check("wr_addr2", config_addr, 32'h6);
    check("wr_novalid", rsp_valid, 1'b0);
    tick;
    check("wr_en_off", config_en, 4'b0);
    check("wr_valid", rsp_valid, 1'b1);
    check("wr_err", rsp_error, 1'b0);
    check("wr_rdata", rsp_data, 32'h0);
    ack;
    issue(1'b0, 32'h0100_0000, 32'h0);
    check("rd_addr", config_addr, 32'h0);
    tick;
    check("rd_en", config_en, 4'b0);
    check("rd_novalid", rsp_valid, 1'b0);
    cb_read_data[63:32] = 32'hdead_beef;
    tick;
    check("rd_valid", rsp_valid, 1'b1);
    check("rd_data", rsp_data, 32'h0007_0070);
    check("rd_err", rsp_error, 1'b0);
    check("rd_en2", config_en, 4'b0);
    ack;
    issue(1'b1, 32'h0500_0000, 32'hdead);
    check("bad_en0", config_en, 4'b0);
    tick;
    check("bad_en1", config_en, 4'b0);
    check("bad_valid", rsp_valid, 1'b1);
    check("bad_err", rsp_error, 1'b1);
    check("bad_data", rsp_data, 32'h0);
    tick;
    check("bad_en2", config_en, 4'b0);
    ack;
    issue(1'b0, 32'h0200_0004, 32'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h0300_0010;
    cmd_data = 32'habcd;
    tick;
    cb_read_data[95:64] = 32'h5555_5555;
    tick;
    check("bp_valid0", rsp_valid, 1'b1);
    check("bp_data0", rsp_data, 32'h2222_2222);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_data", rsp_data, 32'h2222_2222);
      check("bp_ready", cmd_ready, 1'b0);
      check("bp_en", config_en, 4'b0);
    end
    rsp_ready = 1'b1;
    tick;
    check("bp_ack_valid", rsp_valid, 1'b0);
    check("bp_ack_ready", cmd_ready, 1'b0);
    rsp_ready = 1'b0;
    tick;
    check("bp_ready_back", cmd_ready, 1'b1);
    tick;
    cmd_valid = 1'b0;
    check("bp2_ready", cmd_ready, 1'b0);
    check("bp2_addr", config_addr, 32'h10);
    check("bp2_data", config_data, 32'habcd);
    tick;
    check("bp2_en1", config_en, 4'b1000);
    tick;
    check("bp2_en2", config_en, 4'b1000);
    tick;
    check("bp2_valid", rsp_valid, 1'b1);
    check("bp2_en_off", config_en, 4'b0);
    ack;
    issue(1'b1, 32'h0000_0008, 32'h55);
    tick;
    check("mid_en1", config_en, 4'b0001);
    tick;
    check("mid_en2", config_en, 4'b0001);
    reset = 1'b1;
    tick;
    check("mid_rst_en", config_en, 4'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      check("resweep_en", config_en, 4'b1 << (k / 2));
      check("resweep_valid", rsp_valid, 1'b0);
    end
    tick;
    check("resweep_idle", cmd_ready, 1'b1);
    check("resweep_novalid", rsp_valid, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
